// File: rtl/fetch_stage.sv
// fetch_stage: PC, single-outstanding imem requests, IF/ID register.
// Optional FETCH_ALIGN_CHECK_EN traps misaligned redirect targets.
module fetch_stage #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter logic [31:0] NOP_INSN = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [63:0] if_id_pc,
  output logic [31:0] if_id_instruction,
  output logic        if_id_valid,
  output logic        fetch_misaligned
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_HOLD,
    S_DROP
  } state_t;

  state_t      r_state, w_state_nx;
  logic [63:0] r_pc, w_pc_nx;
  logic [63:0] r_req_pc, w_req_pc_nx;
  logic [31:0] r_hold_insn, w_hold_insn_nx;
  logic [63:0] r_hold_pc, w_hold_pc_nx;
  logic [63:0] r_ifid_pc, w_ifid_pc_nx;
  logic [31:0] r_ifid_insn, w_ifid_insn_nx;
  logic        r_ifid_valid, w_ifid_valid_nx;
  logic        w_req_raw;
  logic        w_block;
  logic        w_fire;
  logic [63:0] w_target;

`ifdef FETCH_ALIGN_CHECK_EN
  logic r_misaligned;

  // Sticky trap on a redirect to a non-word-aligned target
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_misaligned <= 1'b0;
    else if (branch_taken && (branch_target[1:0] != 2'b00))
      r_misaligned <= 1'b1;
  end

  assign w_target         = branch_target;
  assign w_block          = r_misaligned;
  assign fetch_misaligned = r_misaligned;
`else
  assign w_target         = branch_target & ~64'h3;
  assign w_block          = 1'b0;
  assign fetch_misaligned = 1'b0;
`endif

  assign w_fire = imem_req & imem_gnt;

  // Request: always in FETCH, back-to-back in WAIT on an accepted response
  always_comb begin
    w_req_raw = 1'b0;
    imem_addr = r_pc;
    unique case (r_state)
      S_FETCH: w_req_raw = 1'b1;
      S_WAIT:  w_req_raw = imem_rvalid & ~stall & ~branch_taken;
      default: w_req_raw = 1'b0;
    endcase
    imem_req = w_req_raw & ~w_block & ~reset;
  end

  // Next-state, PC, hold buffer and IF/ID updates; redirect dominates
  always_comb begin
    w_state_nx      = r_state;
    w_pc_nx         = r_pc;
    w_req_pc_nx     = r_req_pc;
    w_hold_insn_nx  = r_hold_insn;
    w_hold_pc_nx    = r_hold_pc;
    w_ifid_pc_nx    = r_ifid_pc;
    w_ifid_insn_nx  = r_ifid_insn;
    w_ifid_valid_nx = r_ifid_valid;
    if (branch_taken) begin
      w_pc_nx         = w_target;
      w_ifid_pc_nx    = 64'h0;
      w_ifid_insn_nx  = NOP_INSN;
      w_ifid_valid_nx = 1'b0;
      unique case (r_state)
        S_FETCH: w_state_nx = w_fire ? S_DROP : S_FETCH;
        S_WAIT:  w_state_nx = imem_rvalid ? S_FETCH : S_DROP;
        S_HOLD:  w_state_nx = S_FETCH;
        default: w_state_nx = imem_rvalid ? S_FETCH : S_DROP;
      endcase
    end else begin
      unique case (r_state)
        S_FETCH: begin
          if (w_fire) begin
            w_req_pc_nx = r_pc;
            w_pc_nx     = r_pc + 64'd4;
            w_state_nx  = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid && !stall) begin
            w_ifid_pc_nx    = r_req_pc;
            w_ifid_insn_nx  = imem_rdata;
            w_ifid_valid_nx = 1'b1;
            if (w_fire) begin
              w_req_pc_nx = r_pc;
              w_pc_nx     = r_pc + 64'd4;
            end else begin
              w_state_nx = S_FETCH;
            end
          end else if (imem_rvalid) begin
            w_hold_insn_nx = imem_rdata;
            w_hold_pc_nx   = r_req_pc;
            w_state_nx     = S_HOLD;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            w_ifid_pc_nx    = r_hold_pc;
            w_ifid_insn_nx  = r_hold_insn;
            w_ifid_valid_nx = 1'b1;
            w_state_nx      = S_FETCH;
          end
        end
        default: begin
          if (imem_rvalid) w_state_nx = S_FETCH;
        end
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_FETCH;
      r_pc         <= RESET_PC;
      r_req_pc     <= RESET_PC;
      r_hold_insn  <= NOP_INSN;
      r_hold_pc    <= 64'h0;
      r_ifid_pc    <= 64'h0;
      r_ifid_insn  <= NOP_INSN;
      r_ifid_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_pc         <= w_pc_nx;
      r_req_pc     <= w_req_pc_nx;
      r_hold_insn  <= w_hold_insn_nx;
      r_hold_pc    <= w_hold_pc_nx;
      r_ifid_pc    <= w_ifid_pc_nx;
      r_ifid_insn  <= w_ifid_insn_nx;
      r_ifid_valid <= w_ifid_valid_nx;
    end
  end

  assign if_id_pc          = r_ifid_pc;
  assign if_id_instruction = r_ifid_insn;
  assign if_id_valid       = r_ifid_valid;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch_stage against a
// behavioural variable-latency instruction memory.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instruction;
  logic        if_id_valid;
  logic        fetch_misaligned;

  int total;
  int bad;

  fetch_stage #(
    .RESET_PC(64'h1000),
    .NOP_INSN(32'h00000013)
  ) dut (
    .clk(clk),
    .reset(reset),
    .stall(stall),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .if_id_pc(if_id_pc),
    .if_id_instruction(if_id_instruction),
    .if_id_valid(if_id_valid),
    .fetch_misaligned(fetch_misaligned)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a == 64'h1000) return 32'h00500093;
    if (a == 64'h1004) return 32'h00A00113;
    return a[31:0] + 32'h13;
  endfunction

  int          m_lat;
  int          m_cnt;
  logic        m_pend;
  logic [63:0] m_addr;
  logic        m_fired;
  logic [63:0] m_fa;

  always @(posedge clk) begin
    m_fired = imem_req && imem_gnt;
    m_fa    = imem_addr;
    #1;
    imem_rvalid = 1'b0;
    if (reset) begin
      m_pend = 1'b0;
    end else begin
      if (m_pend) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(m_addr);
          m_pend      = 1'b0;
        end
      end
      if (m_fired) begin
        m_addr = m_fa;
        m_cnt  = m_lat - 1;
        if (m_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(m_addr);
        end else begin
          m_pend = 1'b1;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input int lat);
    reset         = 1'b1;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 64'h0;
    imem_gnt      = 1'b1;
    m_lat         = lat;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    m_lat = 1;
    tick();
    tick();
    total++;
    if (imem_req !== 1'b0) begin
      bad++;
      $display("FAIL rst_req got=%b want=0", imem_req);
    end
    total++;
    if (imem_addr !== 64'h1000) begin
      bad++;
      $display("FAIL rst_addr got=%h want=1000", imem_addr);
    end
    total++;
    if (if_id_pc !== 64'h0 || if_id_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_ifid got=%h/%b want=0/0",
               if_id_pc, if_id_valid);
    end
    total++;
    if (if_id_instruction !== 32'h00000013) begin
      bad++;
      $display("FAIL rst_insn got=%h want=00000013",
               if_id_instruction);
    end
    total++;
    if (fetch_misaligned !== 1'b0) begin
      bad++;
      $display("FAIL rst_mis got=%b want=0", fetch_misaligned);
    end
    reset = 1'b0;
    #1;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h1000) begin
      bad++;
      $display("FAIL first_req got=%b/%h want=1/1000",
               imem_req, imem_addr);
    end
  endtask

  task automatic test_stream_stall();
    do_reset(1);
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h1000) begin
      bad++;
      $display("FAIL s_req0 got=%b/%h want=1/1000",
               imem_req, imem_addr);
    end
    tick();
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h1004) begin
      bad++;
      $display("FAIL s_req1 got=%b/%h want=1/1004",
               imem_req, imem_addr);
    end
    tick();
    total++;
    if (if_id_pc !== 64'h1000 || if_id_valid !== 1'b1 ||
        if_id_instruction !== 32'h00500093) begin
      bad++;
      $display("FAIL s_ifid0 got=%h/%h/%b want=1000/00500093/1",
               if_id_pc, if_id_instruction, if_id_valid);
    end
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h1008) begin
      bad++;
      $display("FAIL s_req2 got=%b/%h want=1/1008",
               imem_req, imem_addr);
    end
    tick();
    total++;
    if (if_id_pc !== 64'h1004 || if_id_valid !== 1'b1 ||
        if_id_instruction !== 32'h00A00113) begin
      bad++;
      $display("FAIL s_ifid1 got=%h/%h/%b want=1004/00a00113/1",
               if_id_pc, if_id_instruction, if_id_valid);
    end
    stall = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (imem_req !== 1'b0 || if_id_pc !== 64'h1004 ||
          if_id_valid !== 1'b1) begin
        bad++;
        $display("FAIL st_hold%0d got=%b/%h/%b want=0/1004/1",
                 i, imem_req, if_id_pc, if_id_valid);
      end
      if (i < 2) tick();
    end
    tick();
    stall = 1'b0;
    #1;
    total++;
    if (imem_req !== 1'b0 || if_id_pc !== 64'h1004) begin
      bad++;
      $display("FAIL st_rel got=%b/%h want=0/1004",
               imem_req, if_id_pc);
    end
    tick();
    total++;
    if (if_id_pc !== 64'h1008 || if_id_valid !== 1'b1 ||
        if_id_instruction !== 32'h0000101B) begin
      bad++;
      $display("FAIL st_ifid got=%h/%h/%b want=1008/0000101b/1",
               if_id_pc, if_id_instruction, if_id_valid);
    end
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h100C) begin
      bad++;
      $display("FAIL st_req got=%b/%h want=1/100c",
               imem_req, imem_addr);
    end
  endtask

  task automatic test_redirect_wait();
    do_reset(3);
    tick();
    tick();
    tick();
    tick();
    total++;
    if (if_id_pc !== 64'h1000 || if_id_valid !== 1'b1 ||
        if_id_instruction !== 32'h00500093) begin
      bad++;
      $display("FAIL rw_ifid got=%h/%h/%b want=1000/00500093/1",
               if_id_pc, if_id_instruction, if_id_valid);
    end
    branch_taken  = 1'b1;
    branch_target = 64'h2000;
    #1;
    total++;
    if (imem_req !== 1'b0) begin
      bad++;
      $display("FAIL rw_noreq got=%b want=0", imem_req);
    end
    tick();
    branch_taken = 1'b0;
    #1;
    total++;
    if (if_id_instruction !== 32'h00000013 || if_id_valid !== 1'b0 ||
        if_id_pc !== 64'h0 || imem_req !== 1'b0) begin
      bad++;
      $display("FAIL rw_flush got=%h/%b/%h/%b want=00000013/0/0/0",
               if_id_instruction, if_id_valid, if_id_pc, imem_req);
    end
    tick();
    total++;
    if (imem_rvalid !== 1'b1 || imem_req !== 1'b0) begin
      bad++;
      $display("FAIL rw_drop got=%b/%b want=1/0",
               imem_rvalid, imem_req);
    end
    tick();
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h2000) begin
      bad++;
      $display("FAIL rw_req got=%b/%h want=1/2000",
               imem_req, imem_addr);
    end
    tick();
    tick();
    tick();
    tick();
    total++;
    if (if_id_pc !== 64'h2000 || if_id_valid !== 1'b1 ||
        if_id_instruction !== 32'h00002013) begin
      bad++;
      $display("FAIL rw_tgt got=%h/%h/%b want=2000/00002013/1",
               if_id_pc, if_id_instruction, if_id_valid);
    end
  endtask

  task automatic test_redirect_stall();
    do_reset(1);
    tick();
    tick();
    stall         = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 64'h3000;
    #1;
    total++;
    if (imem_req !== 1'b0) begin
      bad++;
      $display("FAIL rs_noreq got=%b want=0", imem_req);
    end
    tick();
    branch_taken = 1'b0;
    #1;
    total++;
    if (if_id_instruction !== 32'h00000013 || if_id_valid !== 1'b0 ||
        if_id_pc !== 64'h0) begin
      bad++;
      $display("FAIL rs_flush got=%h/%b/%h want=00000013/0/0",
               if_id_instruction, if_id_valid, if_id_pc);
    end
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h3000) begin
      bad++;
      $display("FAIL rs_req got=%b/%h want=1/3000",
               imem_req, imem_addr);
    end
    stall = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset(1);
    imem_gnt = 1'b0;
    tick();
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h1000) begin
      bad++;
      $display("FAIL w_hold got=%b/%h want=1/1000",
               imem_req, imem_addr);
    end
    branch_taken  = 1'b1;
    branch_target = 64'hFFFFFFFFFFFFFFFC;
    tick();
    branch_taken = 1'b0;
    imem_gnt     = 1'b1;
    #1;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 64'hFFFFFFFFFFFFFFFC) begin
      bad++;
      $display("FAIL w_top got=%b/%h want=1/fffffffffffffffc",
               imem_req, imem_addr);
    end
    tick();
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
      bad++;
      $display("FAIL w_wrap got=%b/%h want=1/0", imem_req, imem_addr);
    end
    tick();
    total++;
    if (if_id_pc !== 64'hFFFFFFFFFFFFFFFC ||
        if_id_instruction !== 32'h0000000F || if_id_valid !== 1'b1) begin
      bad++;
      $display("FAIL w_ifid got=%h/%h/%b want=fffffffffffffffc/0000000f/1",
               if_id_pc, if_id_instruction, if_id_valid);
    end
  endtask

  task automatic test_misaligned();
    do_reset(1);
    imem_gnt      = 1'b0;
    branch_taken  = 1'b1;
    branch_target = 64'h2002;
    tick();
    branch_taken = 1'b0;
    imem_gnt     = 1'b1;
    #1;
`ifdef FETCH_ALIGN_CHECK_EN
    for (int i = 0; i < 4; i++) begin
      total++;
      if (fetch_misaligned !== 1'b1 || imem_req !== 1'b0 ||
          if_id_valid !== 1'b0) begin
        bad++;
        $display("FAIL mis_trap%0d got=%b/%b/%b want=1/0/0",
                 i, fetch_misaligned, imem_req, if_id_valid);
      end
      tick();
    end
`else
    total++;
    if (fetch_misaligned !== 1'b0) begin
      bad++;
      $display("FAIL mis_flag got=%b want=0", fetch_misaligned);
    end
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h2000) begin
      bad++;
      $display("FAIL mis_req got=%b/%h want=1/2000",
               imem_req, imem_addr);
    end
`endif
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    clk           = 1'b0;
    reset         = 1'b1;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 64'h0;
    imem_gnt      = 1'b1;
    imem_rvalid   = 1'b0;
    imem_rdata    = 32'h0;
    m_lat         = 1;
    m_cnt         = 0;
    m_pend        = 1'b0;
    m_addr        = 64'h0;
    test_reset();
    test_stream_stall();
    test_redirect_wait();
    test_redirect_stall();
    test_wrap();
    test_misaligned();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 64-bit pipelined core. It holds the PC and issues one-outstanding requests to instruction memory with variable response latency. It captures returned words into the IF/ID pipeline register, whose `if_id_instruction` drives the decode-stage immediate extractor and register-file read. It honours hazard-unit stalls and EX-stage branch redirects, and inserts NOP bubbles on flush.

## Interface
- `RESET_PC`, 64'h0, PC loaded on reset.
- `NOP_INSN`, 32'h00000013, word placed in IF/ID on flush/reset (addi x0,x0,0).

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `stall` in 1: hazard unit holds IF/ID.
- `branch_taken` in 1: EX redirect, single-cycle pulse.
- `branch_target` in 64: redirect PC.
- `imem_req` out 1: request valid.
- `imem_addr` out 64: request address.
- `imem_gnt` in 1: request accepted this cycle.
- `imem_rvalid` in 1: response valid.
- `imem_rdata` in 32: response word.
- `if_id_pc` out 64: PC of `if_id_instruction`.
- `if_id_instruction` out 32: instruction word to decode.
- `if_id_valid` out 1: IF/ID holds a real instruction.
- `fetch_misaligned` out 1: only with `FETCH_ALIGN_CHECK_EN`; otherwise tied 0.

## Operation
- Registers:
  - `pc` (next address to request).
  - `req_pc` (address of the outstanding request).
  - 32-bit hold buffer plus its PC.
  - State machine: FETCH, WAIT, HOLD, DROP.
- FETCH: `imem_req`=1, `imem_addr`=`pc`. On `imem_gnt`: `req_pc`<=`pc`, `pc`<=`pc`+4 (64-bit wrap), go to WAIT.
- WAIT, on `imem_rvalid`:
  - If !`stall`: IF/ID <= {`req_pc`, `imem_rdata`, valid=1}. In the same cycle assert `imem_req` for `pc`. If granted, stay WAIT and update `req_pc`/`pc`; else go to FETCH.
  - If `stall`: store the word in the hold buffer, go to HOLD.
- HOLD: no request. When !`stall`, move the buffer into IF/ID (valid=1) and go to FETCH.
- DROP: a response is in flight for a discarded address. No request. The next `imem_rvalid` is ignored; then go to FETCH.
- Redirect (`branch_taken`=1) has top priority in every state:
  - `pc`<=`branch_target`.
  - IF/ID <= {0, `NOP_INSN`, valid=0}, even if `stall`=1.
  - Hold buffer discarded.
  - From FETCH: if `imem_gnt`=1 in the same cycle, go to DROP; else stay FETCH.
  - From WAIT: if `imem_rvalid`=1 in the same cycle, go to FETCH; else go to DROP.
  - From HOLD: go to FETCH.
  - From DROP: stay DROP, unless `imem_rvalid`=1 that cycle, then go to FETCH.
  - No `imem_req` is raised by the WAIT back-to-back path in a redirect cycle.
- `stall` alone: IF/ID holds all three fields unchanged. A request already in FETCH may still be granted.
- Only one request is ever outstanding. `imem_rvalid` outside WAIT/DROP is ignored.

## Timing
- Reset values:
  - `pc`=`RESET_PC`; state FETCH.
  - `imem_req`=0 while `reset` is asserted; `imem_addr`=`RESET_PC`.
  - `if_id_pc`=0, `if_id_instruction`=`NOP_INSN`, `if_id_valid`=0, `fetch_misaligned`=0.
- First request is raised the first cycle after `reset` deasserts.
- `imem_req`/`imem_addr` are combinational from state, `pc`, `stall`, `imem_rvalid` and `branch_taken`. `imem_addr` never changes while `imem_req`=1 without a grant, except on a redirect.
- Latency: grant in cycle N, `imem_rvalid` in cycle M>=N+1 → IF/ID is visible after the edge ending cycle M.
- With a 1-cycle memory and no stall, the stage sustains 1 instruction/cycle.
- Redirect in cycle N → first request to `branch_target` is in cycle N+1 (if no in-flight response needs dropping).
- Reset mid-transaction: state returns to FETCH immediately. The in-flight response is not tracked; the memory is reset by the same `reset`.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - A redirect with `branch_target[1:0]`!=0 sets `fetch_misaligned` (sticky until reset) and enters DROP/FETCH as normal.
  - It then suppresses all further `imem_req`; IF/ID stays NOP, valid=0.
- Not defined: `branch_target[1:0]` is forced to 2'b00 and `fetch_misaligned` is tied 0.

## Test plan
- Reset with `RESET_PC`=64'h1000, 1-cycle memory returning 32'h00500093, 32'h00A00113 → `imem_addr` sequence 1000, 1004; IF/ID shows pc 1000 then 1004, one per cycle, valid=1.
- `stall`=1 for 3 cycles while the response for 64'h1008 arrives → IF/ID holds 1004 and no new request is made. One cycle after `stall` falls, IF/ID shows 1008 and a request for 100C follows.
- 3-cycle-latency memory, `branch_taken` with target 64'h2000 during WAIT → IF/ID becomes NOP, valid=0. The stale response is dropped; the next request is 2000 and IF/ID later shows pc 2000.
- `branch_taken` and `stall` in the same cycle → IF/ID flushes to 32'h00000013, valid=0.
- `pc`=64'hFFFFFFFFFFFFFFFC, fetched and granted → the next `imem_addr` is 64'h0.
- With `FETCH_ALIGN_CHECK_EN`, redirect to 64'h2002 → `fetch_misaligned`=1 and `imem_req` stays 0 until `reset`. Without the macro, the next request is to 64'h2000.
